// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared instruction definitions for the branch redirect path.
// Opcode values follow the LoongArch major-opcode field, zero-extended to 8 bits.
package branch_redirect_ctrl_pkg;

    localparam logic [7:0] OP_JIRL = 8'h13;
    localparam logic [7:0] OP_B    = 8'h14;
    localparam logic [7:0] OP_BL   = 8'h15;
    localparam logic [7:0] OP_BEQ  = 8'h16;
    localparam logic [7:0] OP_BNE  = 8'h17;
    localparam logic [7:0] OP_BLT  = 8'h18;
    localparam logic [7:0] OP_BGE  = 8'h19;
    localparam logic [7:0] OP_BLTU = 8'h1a;
    localparam logic [7:0] OP_BGEU = 8'h1b;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Turns a resolved taken branch into a one-shot IF redirect with front-end flush,
// raises ADEF on misaligned targets, and counts accepted redirects.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_valid,
    input  logic [7:0]       ex_op,
    input  logic             ex_cond,
    input  logic [31:0]      ex_target,
    input  logic             wb_flush,
    input  logic             redir_ready,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             flush_fd,
    output logic             ex_stall,
    output logic             exc_valid,
    output logic [31:0]      exc_badv,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_redir_valid;
    logic [31:0]      r_redir_pc;
    logic             r_flush_fd;
    logic             r_exc_valid;
    logic [31:0]      r_exc_badv;
    logic [CNT_W-1:0] r_redir_cnt;

    logic w_uncond;
    logic w_cond;
    logic w_taken;
    logic w_aligned;

    assign w_uncond  = ex_op inside {OP_B, OP_BL, OP_JIRL};
    assign w_cond    = ex_op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    assign w_taken   = w_uncond | (w_cond & ex_cond);
    assign w_aligned = (ex_target[1:0] == 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_flush_fd    <= 1'b0;
            r_exc_valid   <= 1'b0;
            r_exc_badv    <= '0;
            r_redir_cnt   <= '0;
        end else begin
            r_exc_valid <= 1'b0;
            // WB flush overrides everything, including a same-cycle accept or new branch.
            if (wb_flush) begin
                r_state       <= S_IDLE;
                r_redir_valid <= 1'b0;
                r_flush_fd    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (ex_valid && w_taken) begin
                            if (w_aligned) begin
                                r_state       <= S_PEND;
                                r_redir_pc    <= ex_target;
                                r_redir_valid <= 1'b1;
                                r_flush_fd    <= 1'b1;
                            end else begin
                                r_exc_valid <= 1'b1;
                                r_exc_badv  <= ex_target;
                            end
                        end
                    end
                    S_PEND: begin
                        if (redir_ready) begin
                            r_state       <= S_DRAIN;
                            r_redir_valid <= 1'b0;
                            r_redir_cnt   <= r_redir_cnt + CNT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        r_state    <= S_IDLE;
                        r_flush_fd <= 1'b0;
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_redir_valid <= 1'b0;
                        r_flush_fd    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ex_stall    = (r_state != S_IDLE);
    assign redir_valid = r_redir_valid;
    assign redir_pc    = r_redir_pc;
    assign flush_fd    = r_flush_fd;
    assign exc_valid   = r_exc_valid;
    assign exc_badv    = r_exc_badv;
    assign redir_cnt   = r_redir_cnt;

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the taken-redirect counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid  in  1  one-cycle pulse: branch-class instruction resolved in EX.
REQ-005 SHALL have port ex_op  in  8  opcode (OP_B, OP_BL, OP_JIRL, conditional OP_B*).
REQ-006 SHALL have port ex_cond  in  1  condition result for conditional branches.
REQ-007 SHALL have port ex_target  in  32  target from EX target adder.
REQ-008 SHALL have port wb_flush  in  1  exception/ertn flush from WB; highest priority.
REQ-009 SHALL have port redir_ready  in  1  IF accepts redirect.
REQ-010 SHALL have port redir_valid  out  1  redirect request to IF.
REQ-011 SHALL have port redir_pc  out  32  redirect target.
REQ-012 SHALL have port flush_fd  out  1  kill IF/ID contents.
REQ-013 SHALL have port ex_stall  out  1  ID must not issue into EX.
REQ-014 SHALL have port exc_valid  out  1  one-cycle ADEF pulse for misaligned target.
REQ-015 SHALL have port exc_badv  out  32  faulting target address.
REQ-016 SHALL have port redir_cnt  out  CNT_W  count of accepted redirects.

Function
REQ-017 SHALL compute taken = ex_op in {OP_B, OP_BL, OP_JIRL}, or conditional op AND ex_cond.
REQ-018 SHALL implement FSM states IDLE, PEND, DRAIN.
REQ-019 IDLE: on ex_valid & taken & ex_target[1:0]==0, SHALL latch ex_target into redir_pc and go to PEND (redirect latency 1 cycle).
REQ-020 IDLE: on ex_valid & taken & ex_target[1:0]!=0, SHALL pulse exc_valid next cycle with exc_badv=ex_target, stay IDLE, no redirect.
REQ-021 IDLE: not-taken or ex_valid=0 SHALL have no effect.
REQ-022 PEND: redir_valid=1, flush_fd=1, ex_stall=1; redir_pc SHALL stay stable until accepted.
REQ-023 PEND & redir_ready: SHALL increment redir_cnt (wraps modulo 2^CNT_W), go to DRAIN.
REQ-024 DRAIN: redir_valid=0, flush_fd=1, ex_stall=1 for exactly one cycle, then IDLE.
REQ-025 ex_valid in PEND or DRAIN SHALL be ignored (protocol violation; bench asserts it never occurs).
REQ-026 wb_flush in any state SHALL force IDLE next cycle, drop redir_valid, suppress pending exc_valid, no count.
REQ-027 wb_flush & redir_ready same cycle in PEND: wb_flush wins, redir_cnt unchanged.
REQ-028 wb_flush & ex_valid same cycle in IDLE: branch discarded.
REQ-029 All outputs SHALL be registered except ex_stall, decoded from state.

Reset
REQ-030 resetn low SHALL asynchronously force IDLE, redir_valid=0, redir_pc=0, flush_fd=0, exc_valid=0, exc_badv=0, redir_cnt=0.
REQ-031 Reset mid-PEND SHALL abandon the redirect with no count.
REQ-032 First action after resetn deasserts SHALL occur on the following rising edge.

Structure
REQ-033 Opcode constants SHALL come from the shared defs header; no local opcode copies.
REQ-034 FSM encoding SHALL be local localparams, not shared.
REQ-035 No sub-module; taken decode inline. Target computation stays outside this block.

Verification
REQ-036 OP_B, ex_target=0x1c00_0100, redir_ready=1 on 2nd cycle -> redir_valid 1 cycle after ex_valid, redir_pc=0x1c00_0100, redir_cnt=1, flush_fd 3 cycles.
REQ-037 OP_BEQ ex_cond=0 -> no redirect, flush_fd=0, redir_cnt unchanged.
REQ-038 OP_JIRL ex_target=0x1c00_0102 -> exc_valid 1 cycle, exc_badv=0x1c00_0102, redir_valid stays 0.
REQ-039 PEND with redir_ready held 0 for 5 cycles -> redir_valid/redir_pc stable 5 cycles; accepted on 6th.
REQ-040 PEND, wb_flush=1 & redir_ready=1 same cycle -> IDLE next, redir_cnt unchanged.
REQ-041 CNT_W=4, 16 accepted redirects -> redir_cnt wraps to 0; resetn pulse mid-PEND -> all outputs 0 immediately.
